// File: rtl/ex_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// ex_muldiv_ctrl
//   Multi-cycle RV32M sequencer sitting beside the execute-stage ALU. It takes
//   the same forwarded id_ex operands as the ALU, owns a retimed multiplier and
//   an iterative restoring divider, freezes the front of the pipeline while it
//   works, and presents its result for one cycle alongside ALU results into
//   ex_mem.
//
// Optional feature macro: MULDIV_EARLY_OUT_EN
//   defined   : divides with |a| < |b| finish in cycle 1, and the DIV state
//               stops as soon as the partial remainder and all remaining
//               dividend bits are zero.
//   undefined : every non-fast-path divide takes exactly XLEN+1 cycles.
//
// Handshake: req_valid is held by id_ex (frozen through stall_out) until the
//   op completes; there is no ready signal. An op is accepted in IDLE when
//   req_valid & !flush, and is consumed at the clock edge that ends the single
//   DONE cycle (resp_valid=1), where id_ex advances past it. flush kills any op
//   in flight, including one whose DONE cycle coincides with the flush.
//
// Ports
//   clk, rst     : clock (rising edge), asynchronous active-high reset
//   req_valid    : id_ex holds a valid M-extension op
//   req_funct3   : 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   req_a/req_b  : forwarded rs1/rs2 values, captured once at accept
//   req_tag      : destination physical tag carried with the request
//   flush        : pipeline redirect, abandons any op in flight
//   stall_out    : freeze IF/ID/EX this cycle
//   resp_valid   : resp_data/resp_tag valid this cycle
//   resp_data    : result (holds last delivered value otherwise)
//   resp_tag     : tag latched at accept (holds last delivered value otherwise)
//   busy         : sequencer not idle
//   state_dbg    : current FSM state (0 IDLE, 1 MUL, 2 DIV, 3 DONE)
// ---------------------------------------------------------------------------
module ex_muldiv_ctrl #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 2,
  parameter int TAG_W      = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [2:0]       req_funct3,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             stall_out,
  output logic             resp_valid,
  output logic [XLEN-1:0]  resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam int CNT_MAX = (XLEN > MUL_CYCLES) ? XLEN : MUL_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Captured request
  logic [2:0]       funct3_q;
  logic [XLEN-1:0]  a_q;
  logic [XLEN-1:0]  b_q;
  logic [TAG_W-1:0] tag_q;
  logic [CNT_W-1:0] cnt_q;

  // Multiplier / divider state
  logic [2*XLEN-1:0] prod_q;
  logic [XLEN-1:0]   quo_q;     // remaining dividend bits (top) + quotient bits (bottom)
  logic [XLEN:0]     rem_q;     // partial remainder
  logic [XLEN-1:0]   dvs_q;     // divisor magnitude
  logic              q_neg_q;
  logic              r_neg_q;
  logic [XLEN-1:0]   div_res_q;

  // Last delivered response, held while resp_valid is low
  logic [XLEN-1:0]   last_data_q;
  logic [TAG_W-1:0]  last_tag_q;

  // ---------------------------------------------------------------------
  // Request decode (accept-cycle combinational)
  // ---------------------------------------------------------------------
  logic             accept;
  logic             req_is_div, req_is_rem, req_sdiv;
  logic             a_neg, b_neg;
  logic [XLEN-1:0]  a_mag, b_mag;
  logic             div_zero, div_ovf, div_fast;
  logic [XLEN-1:0]  fast_res;

  // ---------------------------------------------------------------------
  // Datapath combinational
  // ---------------------------------------------------------------------
  logic              mul_a_sgn, mul_b_sgn;
  logic [2*XLEN-1:0] mul_pa, mul_pb, prod_full;
  logic [XLEN+1:0]   div_shift, div_trial;
  logic [XLEN-1:0]   q_step;
  logic [XLEN:0]     r_step;
  logic              early_term;
  logic              div_last;
  logic [XLEN-1:0]   q_sel, r_sel, div_fixed;
  logic [XLEN-1:0]   done_res;

  always_comb begin
    accept     = (state_q == S_IDLE) && req_valid && !flush;
    req_is_div = req_funct3[2];
    req_is_rem = req_funct3[1];
    req_sdiv   = !req_funct3[0];
    a_neg      = req_sdiv && req_a[XLEN-1];
    b_neg      = req_sdiv && req_b[XLEN-1];
    a_mag      = a_neg ? -req_a : req_a;
    b_mag      = b_neg ? -req_b : req_b;
    div_zero   = (req_b == '0);
    div_ovf    = req_sdiv && (req_a == {1'b1, {(XLEN-1){1'b0}}}) && (req_b == '1);
    div_fast   = div_zero || div_ovf;
    if (div_zero)     fast_res = req_is_rem ? req_a : '1;
    else if (div_ovf) fast_res = req_is_rem ? '0 : req_a;
    else              fast_res = req_is_rem ? req_a : '0;
`ifdef MULDIV_EARLY_OUT_EN
    // Dividend smaller than divisor: quotient 0, remainder is the dividend.
    if (!div_zero && (a_mag < b_mag)) div_fast = 1'b1;
`endif
  end

  always_comb begin
    // Signed operands are sign-extended to 2*XLEN; the low 2*XLEN bits of the
    // plain product are then the correct signed/unsigned product.
    mul_a_sgn = (funct3_q == 3'd1) || (funct3_q == 3'd2);
    mul_b_sgn = (funct3_q == 3'd1);
    mul_pa    = {{XLEN{mul_a_sgn && a_q[XLEN-1]}}, a_q};
    mul_pb    = {{XLEN{mul_b_sgn && b_q[XLEN-1]}}, b_q};
    prod_full = mul_pa * mul_pb;

    // One restoring step: shift in the next dividend bit, try subtracting.
    div_shift = {rem_q, quo_q[XLEN-1]};
    div_trial = div_shift - {2'b00, dvs_q};
    if (div_trial[XLEN+1]) begin
      r_step = div_shift[XLEN:0];
      q_step = {quo_q[XLEN-2:0], 1'b0};
    end else begin
      r_step = div_trial[XLEN:0];
      q_step = {quo_q[XLEN-2:0], 1'b1};
    end

    early_term = 1'b0;
    q_sel      = q_step;
    r_sel      = r_step[XLEN-1:0];
`ifdef MULDIV_EARLY_OUT_EN
    // Nothing left to divide: the remaining quotient bits are all zero, so
    // the quotient collected so far only needs shifting into place.
    if ((rem_q == '0) && ((quo_q >> cnt_q) == '0)) begin
      early_term = 1'b1;
      q_sel      = quo_q << (CNT_W'(XLEN) - cnt_q);
      r_sel      = '0;
    end
`endif
    div_last = early_term || (cnt_q == DIV_LAST);

    // Quotient negative iff operand signs differ; remainder follows dividend.
    if (funct3_q[1]) div_fixed = r_neg_q ? -r_sel : r_sel;
    else             div_fixed = q_neg_q ? -q_sel : q_sel;

    if (funct3_q[2])          done_res = div_res_q;
    else if (funct3_q == '0)  done_res = prod_q[XLEN-1:0];
    else                      done_res = prod_q[2*XLEN-1:XLEN];
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (req_valid) begin
          if (!req_is_div)   state_d = S_MUL;
          else if (div_fast) state_d = S_DONE;
          else               state_d = S_DIV;
        end
        S_MUL:  if (cnt_q == MUL_LAST) state_d = S_DONE;
        S_DIV:  if (div_last) state_d = S_DONE;
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    resp_valid = (state_q == S_DONE) && !flush;
    resp_data  = resp_valid ? done_res : last_data_q;
    resp_tag   = resp_valid ? tag_q : last_tag_q;
    // Reset forces the freeze off even if id_ex still presents a request.
    stall_out  = req_valid && !flush && (state_q != S_DONE) && !rst;
    busy       = (state_q != S_IDLE);
    state_dbg  = state_q;
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      funct3_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      tag_q       <= '0;
      cnt_q       <= '0;
      prod_q      <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      div_res_q   <= '0;
      last_data_q <= '0;
      last_tag_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          funct3_q <= req_funct3;
          a_q      <= req_a;
          b_q      <= req_b;
          tag_q    <= req_tag;
          cnt_q    <= '0;
          quo_q    <= a_mag;
          rem_q    <= '0;
          dvs_q    <= b_mag;
          q_neg_q  <= a_neg ^ b_neg;
          r_neg_q  <= a_neg;
          if (div_fast) div_res_q <= fast_res;
        end
        S_MUL: begin
          prod_q <= prod_full;
          cnt_q  <= cnt_q + 1'b1;
        end
        S_DIV: begin
          quo_q <= q_step;
          rem_q <= r_step;
          cnt_q <= cnt_q + 1'b1;
          if (div_last) div_res_q <= div_fixed;
        end
        default: ;
      endcase
      if (resp_valid) begin
        last_data_q <= done_res;
        last_tag_q  <= tag_q;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
module tb_ex_muldiv_ctrl;

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [2:0]  req_funct3;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [5:0]  req_tag;
  logic        flush;
  logic        stall_out;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [5:0]  resp_tag;
  logic        busy;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  ex_muldiv_ctrl #(.XLEN(32), .MUL_CYCLES(2), .TAG_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_funct3 (req_funct3),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_tag    (req_tag),
    .flush      (flush),
    .stall_out  (stall_out),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_tag   (resp_tag),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // ---------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_data = '0;
  logic [31:0] last_tag  = '0;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int SMALL_DIV_CYC = 1;
`else
  localparam int SMALL_DIV_CYC = 33;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Driver: issue one op at the next negedge (cycle 0), hold req_valid while
  // stalled (scrambling the forwarded operands after accept), wait for the
  // response, check latency/data/tag, then retire the op.
  // ---------------------------------------------------------------------
  task automatic do_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [5:0] tag,
                       input logic [31:0] exp_data, input int exp_cyc);
    int          cyc;
    logic        got;
    logic [31:0] e;
    @(negedge clk);
    flush      = 1'b0;
    req_valid  = 1'b1;
    req_funct3 = f3;
    req_a      = a;
    req_b      = b;
    req_tag    = tag;
    exp_q.push_back(exp_data);
    #1;
    check({name, "_idle_at_accept"}, {31'b0, busy}, 32'd0);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc <= 100) begin
      if (resp_valid) begin
        got = 1'b1;
      end else begin
        check({name, "_stall"}, {31'b0, stall_out}, 32'd1);
        @(negedge clk);
        req_a = $urandom;
        req_b = $urandom;
        cyc++;
        #1;
      end
    end
    check({name, "_resp_seen"}, {31'b0, got}, 32'd1);
    if (got) begin
      check({name, "_latency"}, cyc, exp_cyc);
      check({name, "_stall_done"}, {31'b0, stall_out}, 32'd0);
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = 32'hDEADBEEF;
      check({name, "_data"}, resp_data, e);
      check({name, "_tag"}, {26'b0, resp_tag}, {26'b0, tag});
      last_data = e;
      last_tag  = {26'b0, tag};
    end
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check({name, "_resp_one_cycle"}, {31'b0, resp_valid}, 32'd0);
    check({name, "_idle_after"}, {31'b0, busy}, 32'd0);
    check({name, "_data_hold"}, resp_data, last_data);
    check({name, "_tag_hold"}, {26'b0, resp_tag}, last_tag);
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_funct3 = '0;
    req_a      = '0;
    req_b      = '0;
    req_tag    = '0;
    flush      = 1'b0;
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_stall", {31'b0, stall_out}, 32'd0);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_tag", {26'b0, resp_tag}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Multiplies
    do_op("mul",    3'd0, 32'd7,        32'hFFFFFFFD, 6'd5, 32'hFFFFFFEB, 3);
    do_op("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd1, 32'hFFFFFFFE, 3);
    do_op("mulh",   3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd2, 32'h00000000, 3);
    do_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd3, 32'hFFFFFFFF, 3);
    do_op("mul_pos",3'd0, 32'd12345,    32'd1000,     6'd4, 32'd12345000, 3);

    // Full-length divides
    do_op("div_neg",  3'd4, 32'hFFFFFFEC, 32'd6,        6'd10, 32'hFFFFFFFD, 33);
    do_op("rem_neg",  3'd6, 32'hFFFFFFEC, 32'd6,        6'd11, 32'hFFFFFFFE, 33);
    do_op("divu",     3'd5, 32'd100,      32'd7,        6'd12, 32'd14,       33);
    do_op("remu",     3'd7, 32'd100,      32'd7,        6'd13, 32'd2,        33);
    do_op("div_negb", 3'd4, 32'd20,       32'hFFFFFFFA, 6'd14, 32'hFFFFFFFD, 33);
    do_op("rem_negb", 3'd6, 32'd7,        32'hFFFFFFFE, 6'd15, 32'd1,        33);

    // Fast paths and small-dividend case
    do_op("divu_by0", 3'd5, 32'd9,        32'd0,        6'd20, 32'hFFFFFFFF, 1);
    do_op("remu_by0", 3'd7, 32'd9,        32'd0,        6'd21, 32'd9,        1);
    do_op("rem_ovf",  3'd6, 32'h80000000, 32'hFFFFFFFF, 6'd22, 32'd0,        1);
    do_op("div_ovf",  3'd4, 32'h80000000, 32'hFFFFFFFF, 6'd23, 32'h80000000, 1);
    do_op("divu_small", 3'd5, 32'd3,      32'd10,       6'd24, 32'd0,        SMALL_DIV_CYC);

    // Flush in the DONE cycle suppresses the response
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = 3'd5; req_a = 32'd9; req_b = 32'd0; req_tag = 6'd25;
    #1;
    check("flush_done_stall_accept", {31'b0, stall_out}, 32'd1);
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_done_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("flush_done_stall", {31'b0, stall_out}, 32'd0);
    check("flush_done_data_hold", resp_data, last_data);
    check("flush_done_tag_hold", {26'b0, resp_tag}, last_tag);
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    #1;
    check("flush_done_idle", {31'b0, busy}, 32'd0);

    // Flush at cycle 10 of a divide, then a MUL the following cycle
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = 3'd4; req_a = 32'hFFFFFFEC; req_b = 32'd6; req_tag = 6'd30;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      #1;
      check("flush_div_no_resp", {31'b0, resp_valid}, 32'd0);
      check("flush_div_busy", {31'b0, busy}, 32'd1);
    end
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_div_stall", {31'b0, stall_out}, 32'd0);
    check("flush_div_resp", {31'b0, resp_valid}, 32'd0);
    do_op("mul_after_flush", 3'd0, 32'd6, 32'd7, 6'd31, 32'd42, 3);

    // Asynchronous reset between edges in the middle of a divide
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = 3'd4; req_a = 32'd1000; req_b = 32'd3; req_tag = 6'd40;
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1; req_valid = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_stall", {31'b0, stall_out}, 32'd0);
    check("arst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("arst_resp_data", resp_data, 32'd0);
    check("arst_resp_tag", {26'b0, resp_tag}, 32'd0);
    #1;
    rst = 1'b0;
    last_data = '0;
    last_tag  = '0;
    do_op("divu_after_rst", 3'd5, 32'd1000,     32'd3, 6'd41, 32'd333,       33);
    do_op("rem_after_rst",  3'd6, 32'hFFFFFFF9, 32'd2, 6'd42, 32'hFFFFFFFF, 33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound on the whole run
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
